// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor (package sub_pkg).
// Optional signed-overflow output is controlled by SUB_OVERFLOW_EN.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic RST_BIT = 1'b0;

  // Counter width for a WIDTH-bit operand; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow-out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/done handshake.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last answer
// SHIFT | one result bit per cycle, WIDTH cycles
// DONE  | publish diff/bout (and ovf), pulse done next cycle
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d_bit;
  logic             brw_nxt;
`ifdef SUB_OVERFLOW_EN
  logic             brw_msb;
`endif

  fullsubtractor u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (brw_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      brw   <= RST_BIT;
      busy  <= RST_BIT;
      done  <= RST_BIT;
      diff  <= '0;
      bout  <= RST_BIT;
`ifdef SUB_OVERFLOW_EN
      brw_msb <= RST_BIT;
      ovf     <= RST_BIT;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= in_a;
            sh_b  <= in_b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res  <= {d_bit, res[WIDTH-1:1]};
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          brw  <= brw_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef SUB_OVERFLOW_EN
            // Borrow entering the sign bit, needed for two's-complement overflow.
            brw_msb <= brw;
`endif
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          diff  <= res;
          bout  <= brw;
          done  <= 1'b1;
`ifdef SUB_OVERFLOW_EN
          ovf   <= brw_msb ^ brw;
`endif
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
